// File: rtl/hack_fetch_unit.sv
// Hack CPU fetch stage: owns the PC, drives the ROM address and returns PC-tagged words.
// Latency: address issued in cycle N yields instr_valid in cycle N+2 (ROM reg + output reg).
// Backpressure: stall holds the output; a one-entry skid catches the single in-flight ROM word.
module hack_fetch_unit #(
    parameter int ADDR_W  = 15,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               stall,
    input  logic               jump_valid,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid
);

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic               inflight_v_q, inflight_v_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic               out_v_q, out_v_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               skid_v_q, skid_v_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;

    logic issue;
    logic accept;

    // Blocking issue while the skid is full is what keeps the skid at one entry.
    assign issue  = run && !stall && !skid_v_q && !jump_valid;
    assign accept = !out_v_q || !stall;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_v_d  = 1'b0;
        inflight_pc_d = inflight_pc_q;
        out_v_d       = out_v_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        skid_v_d      = skid_v_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;

        if (jump_valid) begin
            fetch_pc_d = jump_target;
            skid_v_d   = 1'b0;
            out_v_d    = 1'b0;
        end else begin
            if (issue) begin
                inflight_v_d  = 1'b1;
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + 1'b1;
            end

            if (accept) begin
                if (skid_v_q) begin
                    out_v_d    = 1'b1;
                    instr_d    = skid_instr_q;
                    instr_pc_d = skid_pc_q;
                    skid_v_d   = 1'b0;
                end else if (inflight_v_q) begin
                    out_v_d    = 1'b1;
                    instr_d    = rom_data;
                    instr_pc_d = inflight_pc_q;
                end else begin
                    out_v_d    = 1'b0;
                end
            end else if (inflight_v_q) begin
                skid_v_d     = 1'b1;
                skid_instr_d = rom_data;
                skid_pc_d    = inflight_pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q    <= '0;
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= '0;
            out_v_q       <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            skid_v_q      <= 1'b0;
            skid_instr_q  <= '0;
            skid_pc_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_v_q  <= inflight_v_d;
            inflight_pc_q <= inflight_pc_d;
            out_v_q       <= out_v_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            skid_v_q      <= skid_v_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
        end
    end

    assign rom_addr    = fetch_pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = out_v_q;

endmodule

// File: tb/tb_hack_fetch_unit.sv
// Randomised fetch-unit bench: expected PC stream queued by the driver, consumed by a negedge monitor.
module tb_hack_fetch_unit;
    localparam int AW = 15;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          run;
    logic          stall;
    logic          jump_valid;
    logic [AW-1:0] jump_target;
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_data;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;

    always #5 clk = ~clk;

    hack_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .rom_addr(rom_addr),
        .rom_data(rom_data), .stall(stall), .jump_valid(jump_valid),
        .jump_target(jump_target), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid)
    );

    logic [IW-1:0] rom_mem [0:32767];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int            total = 0;
    int            bad = 0;
    int            consumed = 0;
    int            epoch = 0;
    logic [AW-1:0] exp_q [$];
    logic [AW-1:0] seg_next;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference: after reset or a jump the consumer must see target, target+1, ... mod 2^15.
    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(seg_next);
            seg_next = seg_next + 15'd1;
        end
    endtask

    task automatic step(input bit st, input bit rn, input bit jv, input logic [AW-1:0] jt);
        @(posedge clk);
        #1;
        if (jump_valid) begin
            exp_q.delete();
            seg_next = jump_target;
            epoch++;
        end
        stall       = st;
        run         = rn;
        jump_valid  = jv;
        jump_target = jt;
        refill();
    endtask

    // Monitor: a word is consumed at an edge where instr_valid=1 and stall=0.
    logic          hold_v = 1'b0;
    logic [AW-1:0] hold_pc;
    logic [IW-1:0] hold_instr;
    int            hold_epoch;
    logic [AW-1:0] pop_pc;

    always @(negedge clk) begin
        if (hold_v && hold_epoch == epoch && reset_n) begin
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_pc", 32'(instr_pc), 32'(hold_pc));
            chk("hold_instr", 32'(instr), 32'(hold_instr));
        end
        hold_v = 1'b0;
        if (reset_n && instr_valid) begin
            if (stall) begin
                hold_v     = 1'b1;
                hold_pc    = instr_pc;
                hold_instr = instr;
                hold_epoch = epoch;
            end else if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got pc 0x%0h, required none", instr_pc);
            end else begin
                pop_pc = exp_q.pop_front();
                chk("sb_pc", 32'(instr_pc), 32'(pop_pc));
                chk("sb_instr", 32'(instr), 32'(rom_mem[pop_pc]));
                consumed++;
            end
        end
    end

    initial begin
        for (int i = 0; i < 32768; i++) rom_mem[i] = IW'($urandom);
        rom_mem[0] = 16'h0002;
        rom_mem[1] = 16'hEC10;
        rom_mem[2] = 16'h0003;
        rom_mem[3] = 16'hE090;
        rom_mem[6] = 16'hEA87;

        reset_n = 1'b0; run = 1'b0; stall = 1'b0; jump_valid = 1'b0; jump_target = '0;
        seg_next = '0;
        #3;
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_pc", 32'(instr_pc), 32'd0);

        // Start streaming: valid appears after the second edge.
        @(negedge clk);
        reset_n = 1'b1; run = 1'b1;
        refill();
        @(negedge clk);
        chk("lat_e1_valid", 32'(instr_valid), 32'd0);
        chk("lat_e1_addr", 32'(rom_addr), 32'd1);
        @(negedge clk);
        chk("lat_e2_valid", 32'(instr_valid), 32'd1);
        chk("lat_e2_pc", 32'(instr_pc), 32'd0);
        chk("lat_e2_instr", 32'(instr), 32'h0002);
        chk("lat_e2_addr", 32'(rom_addr), 32'd2);

        // Stall for three cycles while pc 1 is presented, then release.
        step(1, 1, 0, '0); step(1, 1, 0, '0); step(1, 1, 0, '0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, '0);

        // Jump to 6.
        step(0, 1, 1, 15'd6);
        step(0, 1, 0, '0);
        chk("jmp6_valid", 32'(instr_valid), 32'd0);
        chk("jmp6_addr", 32'(rom_addr), 32'd6);
        for (int i = 0; i < 6; i++) step(0, 1, 0, '0);

        // Jump while stalled with the skid full.
        step(1, 1, 0, '0); step(1, 1, 0, '0); step(1, 1, 0, '0);
        step(1, 1, 1, 15'd100);
        step(1, 1, 0, '0);
        chk("jmpstall_valid", 32'(instr_valid), 32'd0);
        chk("jmpstall_addr", 32'(rom_addr), 32'd100);
        step(1, 1, 0, '0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, '0);

        // PC wrap.
        step(0, 1, 1, 15'd32766);
        for (int i = 0; i < 10; i++) step(0, 1, 0, '0);

        // Asynchronous reset between edges.
        @(posedge clk);
        #3;
        reset_n = 1'b0; jump_valid = 1'b0; stall = 1'b0; run = 1'b1;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_addr", 32'(rom_addr), 32'd0);
        chk("arst_pc", 32'(instr_pc), 32'd0);
        exp_q.delete();
        seg_next = '0;
        epoch++;
        refill();
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("arst_e1_valid", 32'(instr_valid), 32'd0);
        chk("arst_e1_addr", 32'(rom_addr), 32'd1);
        @(negedge clk);
        chk("arst_e2_valid", 32'(instr_valid), 32'd1);
        chk("arst_e2_pc", 32'(instr_pc), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit            st, rn, jv;
            logic [AW-1:0] jt;
            st = ($urandom_range(0, 99) < 30);
            rn = ($urandom_range(0, 99) < 92);
            jv = ($urandom_range(0, 99) < 4);
            jt = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 32767))
                                             : AW'($urandom_range(32760, 32767));
            step(st, rn, jv, jt);
        end
        for (int i = 0; i < 20; i++) step(0, 1, 0, '0);

        chk("liveness", (consumed >= 500) ? 32'd1 : 32'd0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
